// File: rtl/bit_serializer_if.sv
// Handshake and serial-output bundle for bit_serializer.
// master drives parallel words in; slave is the serializer.
interface bit_serializer_if #(
    parameter int WIDTH = 8
) ();
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic             out_bit;
    logic             out_valid;
    logic             out_last;

    modport master (
        output in_data,
        output in_valid,
        input  in_ready,
        input  out_bit,
        input  out_valid,
        input  out_last
    );

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready,
        output out_bit,
        output out_valid,
        output out_last
    );
endinterface

// File: rtl/bit_serializer.sv
// Parallel-to-serial converter with one holding buffer for gapless frames.
// Optional even-parity bit per frame when SER_PARITY_EN is defined.
module bit_serializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    bit_serializer_if.slave  bus
);
`ifdef SER_PARITY_EN
    localparam int FRAME = WIDTH + 1;
`else
    localparam int FRAME = WIDTH;
`endif
    localparam int CW = $clog2(FRAME + 1);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic             hold_full_q, hold_full_d;
    logic [WIDTH-1:0] shift_nx_s;
    logic             accept_s;
    logic             last_s;
    logic             valid_s;
    logic             data_bit_s;

`ifdef SER_PARITY_EN
    logic             par_q, par_d;

    function automatic logic even_parity(input logic [WIDTH-1:0] w);
        return ^w;
    endfunction
`endif

    assign bus.in_ready = reset & ~hold_full_q;
    assign accept_s     = bus.in_valid & bus.in_ready;
    assign valid_s      = (state_q == SHIFT);
    assign last_s       = valid_s && (cnt_q == CW'(FRAME - 1));
    assign shift_nx_s   = MSB_FIRST ? {shift_q[WIDTH-2:0], 1'b0} : {1'b0, shift_q[WIDTH-1:1]};
    assign data_bit_s   = MSB_FIRST ? shift_q[WIDTH-1] : shift_q[0];

`ifdef SER_PARITY_EN
    assign bus.out_bit  = valid_s & ((cnt_q == CW'(WIDTH)) ? par_q : data_bit_s);
`else
    assign bus.out_bit  = valid_s & data_bit_s;
`endif
    assign bus.out_valid = valid_s;
    assign bus.out_last  = last_s;

    // Next-state: load, shift, refill from buffer or fall back to idle.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        shift_d     = shift_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
`ifdef SER_PARITY_EN
        par_d       = par_q;
`endif
        case (state_q)
            IDLE: begin
                if (accept_s) begin
                    state_d = SHIFT;
                    shift_d = bus.in_data;
                    cnt_d   = '0;
`ifdef SER_PARITY_EN
                    par_d   = even_parity(bus.in_data);
`endif
                end else begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                if (last_s) begin
                    cnt_d = '0;
                    if (hold_full_q) begin
                        shift_d     = hold_q;
                        hold_full_d = 1'b0;
`ifdef SER_PARITY_EN
                        par_d       = even_parity(hold_q);
`endif
                    end else if (accept_s) begin
                        shift_d = bus.in_data;
`ifdef SER_PARITY_EN
                        par_d   = even_parity(bus.in_data);
`endif
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    shift_d = shift_nx_s;
                    cnt_d   = cnt_q + CW'(1);
                    // A word arriving mid-frame parks in the buffer until the frame ends.
                    if (accept_s) begin
                        hold_d      = bus.in_data;
                        hold_full_d = 1'b1;
                    end else begin
                        hold_full_d = hold_full_q;
                    end
                end
            end
            default: begin
                state_d     = IDLE;
                cnt_d       = '0;
                hold_full_d = 1'b0;
            end
        endcase
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            shift_q     <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
`ifdef SER_PARITY_EN
            par_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shift_q     <= shift_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
`ifdef SER_PARITY_EN
            par_q       <= par_d;
`endif
        end
    end
endmodule
